// File: rtl/synaptic_weight_accumulator.sv
// Sums spike weights per timestep and hands the snapshot to the
// potential adder; forwards neuron parameter writes in config mode.
`ifndef DEFAULT
`define DEFAULT 3'd0
`endif

module synaptic_weight_accumulator #(
    parameter bit SATURATE = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        time_step,
    input  logic [2:0]  init_mode,
    input  logic [31:0] weight_in,
    input  logic        weight_valid,
    output logic        weight_ready,
    input  logic        adder_done,
    output logic [31:0] input_weight,
    output logic        load,
    output logic        adder_time_step,
    output logic        busy,
    output logic        overrun,
    output logic        sat_flag
);

    typedef enum logic [1:0] {ACCUM, SNAP, WAIT_DONE} state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] acc;
    logic        pending;
    logic        prev_ts;
    logic        prev_done;

    logic        ts_edge;
    logic        done_edge;
    logic        cfg_mode;
    logic        snap_go;
    logic        xfer;
    logic        run_xfer;
    logic        cfg_xfer;
    logic [32:0] sum;
    logic        sum_ovf;
    logic [31:0] sum_q;

    assign ts_edge   = time_step && !prev_ts;
    assign done_edge = adder_done && !prev_done;
    assign cfg_mode  = (init_mode != `DEFAULT);
    assign snap_go   = (state == ACCUM) && (ts_edge || pending);
    assign busy      = (state != ACCUM);

    // Config writes must not collide with a snapshot on input_weight
    assign weight_ready = !cfg_mode ||
                          ((state == ACCUM) && !load && !snap_go);

    assign xfer     = weight_valid && weight_ready;
    assign run_xfer = xfer && !cfg_mode;
    assign cfg_xfer = xfer && cfg_mode;

    always_comb begin
        sum     = {acc[31], acc} + {weight_in[31], weight_in};
        sum_ovf = sum[32] ^ sum[31];
        sum_q   = sum[31:0];
        if (SATURATE && sum_ovf) begin
            sum_q = sum[32] ? 32'h8000_0000 : 32'h7fff_ffff;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ACCUM:     if (snap_go) state_nxt = SNAP;
            SNAP:      state_nxt = WAIT_DONE;
            WAIT_DONE: if (done_edge) state_nxt = ACCUM;
            default:   state_nxt = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= ACCUM;
            acc             <= '0;
            pending         <= 1'b0;
            prev_ts         <= 1'b0;
            prev_done       <= 1'b0;
            input_weight    <= '0;
            load            <= 1'b0;
            adder_time_step <= 1'b0;
            overrun         <= 1'b0;
            sat_flag        <= 1'b0;
        end else begin
            state     <= state_nxt;
            prev_ts   <= time_step;
            prev_done <= adder_done;
            load      <= cfg_xfer;

            // A weight arriving with the boundary opens the new timestep
            if (snap_go) begin
                input_weight <= acc;
                acc          <= run_xfer ? weight_in : '0;
            end else if (run_xfer) begin
                acc <= sum_q;
                if (SATURATE && sum_ovf) sat_flag <= 1'b1;
            end

            if (cfg_xfer) input_weight <= weight_in;

            if (snap_go) begin
                pending <= 1'b0;
            end else if (busy && ts_edge) begin
                pending <= 1'b1;
                overrun <= 1'b1;
            end

            if (state == SNAP) begin
                adder_time_step <= 1'b1;
            end else if (state == WAIT_DONE && done_edge) begin
                adder_time_step <= 1'b0;
            end
        end
    end

endmodule
